// File: rtl/lowbit_sched_pkg.sv
// lowbit_sched_pkg: shared constants and types for the lowbit request scheduler.
//   N_REQ / ID_W : requester count and width of the 1-based grant id
//   state_t      : scheduler FSM encoding (ST_IDLE / ST_OFFER)
//   ID_NONE, MASK_RST, LAST_RST : reset and "no grant" values
//   id_onehot()  : converts a 1-based id to its one-hot requester bit (0 -> none)
package lowbit_sched_pkg;

    localparam int N_REQ = 32;
    localparam int ID_W  = 6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    localparam logic [ID_W-1:0]  ID_NONE  = '0;
    localparam logic [N_REQ-1:0] MASK_RST = '1;
    localparam logic [4:0]       LAST_RST = 5'd31;

    function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] oh;
        logic [4:0]       idx;
        oh  = '0;
        idx = 5'(id - 6'd1);
        if (id != ID_NONE) oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/lowbit_sched_if.sv
// lowbit_sched_if: request / mask / grant bundle between the requesters, the
// service-port consumer and the scheduler.
//   req, mask_we, mask_wdata, rr_mode, gnt_ack : toward the scheduler
//   gnt_valid, gnt_id, pending, mask          : from the scheduler
// master = environment side, slave = scheduler side.
interface lowbit_sched_if;
    import lowbit_sched_pkg::*;

    logic [N_REQ-1:0] req;
    logic             mask_we;
    logic [N_REQ-1:0] mask_wdata;
    logic             rr_mode;
    logic             gnt_valid;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_ack;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] mask;

    modport master (
        output req, mask_we, mask_wdata, rr_mode, gnt_ack,
        input  gnt_valid, gnt_id, pending, mask
    );

    modport slave (
        input  req, mask_we, mask_wdata, rr_mode, gnt_ack,
        output gnt_valid, gnt_id, pending, mask
    );

endinterface

// File: rtl/lowbit_sched_lowbit.sv
// lowbit: 32-bit lowest-set-bit encoder.
//   i_vec : input vector
//   o_id  : 1-based index of the lowest set bit, 0 when i_vec is all zero
module lowbit
    import lowbit_sched_pkg::*;
(
    input  logic [N_REQ-1:0] i_vec,
    output logic [ID_W-1:0]  o_id
);

    // Scan downward so the last hit (lowest index) is the one that sticks.
    always_comb begin
        o_id = ID_NONE;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_vec[i]) o_id = ID_W'(i + 1);
        end
    end

endmodule

// File: rtl/lowbit_sched.sv
// lowbit_sched: 32-requester scheduler. Latches request pulses into a pending
// register, picks one eligible (pending & mask) requester by fixed lowest-index
// priority or round-robin, and offers its 1-based id on a valid/ack handshake.
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : lowbit_sched_if.slave (req, mask write, rr_mode, grant handshake,
//             pending / mask status)
module lowbit_sched
    import lowbit_sched_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    lowbit_sched_if.slave  bus
);

    state_t           r_state;
    logic [N_REQ-1:0] r_pending;
    logic [N_REQ-1:0] r_mask;
    logic [4:0]       r_last;
    logic             r_gnt_valid;
    logic [ID_W-1:0]  r_gnt_id;

    logic [N_REQ-1:0] w_eligible;
    logic [N_REQ-1:0] w_above;
    logic [ID_W-1:0]  w_id_above;
    logic [ID_W-1:0]  w_id_all;
    logic [ID_W-1:0]  w_winner;
    logic             w_accept;
    logic [N_REQ-1:0] w_clr;

    assign w_eligible = r_pending & r_mask;

    // Bits strictly above the last accepted grant; empty when r_last = 31,
    // which makes round-robin fall back to plain lowest-index priority.
    for (genvar g = 0; g < N_REQ; g++) begin : g_above
        assign w_above[g] = (5'(g) > r_last);
    end

    lowbit u_lowbit_above (
        .i_vec (w_eligible & w_above),
        .o_id  (w_id_above)
    );

    lowbit u_lowbit_all (
        .i_vec (w_eligible),
        .o_id  (w_id_all)
    );

    // Round-robin wraps to bit 0 when nothing eligible lies above r_last.
    assign w_winner = (bus.rr_mode && (w_id_above != ID_NONE)) ? w_id_above : w_id_all;

    assign w_accept = r_gnt_valid & bus.gnt_ack;
    assign w_clr    = w_accept ? id_onehot(r_gnt_id) : '0;

    // A fresh req on the bit being cleared wins, so the requester re-pends.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_mask    <= MASK_RST;
        end else begin
            r_pending <= (r_pending & ~w_clr) | bus.req;
            if (bus.mask_we) r_mask <= bus.mask_wdata;
        end
    end

    // Offer is held unchanged until acked; mask/rr_mode only affect the next
    // IDLE selection. Ack while IDLE is ignored.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= ID_NONE;
            r_last      <= LAST_RST;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_eligible != '0) begin
                        r_gnt_id    <= w_winner;
                        r_gnt_valid <= 1'b1;
                        r_state     <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (bus.gnt_ack) begin
                        r_last      <= 5'(r_gnt_id - 6'd1);
                        r_gnt_valid <= 1'b0;
                        r_gnt_id    <= ID_NONE;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_gnt_valid <= 1'b0;
                    r_gnt_id    <= ID_NONE;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_valid = r_gnt_valid;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.pending   = r_pending;
    assign bus.mask      = r_mask;

endmodule

// File: doc/lowbit_sched.md
# lowbit_sched

Request scheduler for 32 requesters. Latches request pulses into a pending register. Selects one eligible requester per grant, by fixed lowest-index priority or by round-robin. Offers the winner's 1-based id on a valid/ack handshake. Sits between the peripheral/exception request lines and the consumer of the single shared service port, and reuses the team's `lowbit` encoder for selection.

## Interface
- `N_REQ`, 32, number of requesters; fixed at 32 to match `lowbit` width.
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req`  in  32  request lines; any cycle with bit i = 1 sets pending[i].
- `mask_we`  in  1  write strobe for the enable mask.
- `mask_wdata`  in  32  new mask value (1 = requester enabled).
- `rr_mode`  in  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- `gnt_valid`  out  1  an offer is presented.
- `gnt_id`  out  6  granted requester, 1..32; 0 whenever `gnt_valid` = 0.
- `gnt_ack`  in  1  consumer accepts the offer.
- `pending`  out  32  current pending register.
- `mask`  out  32  current enable mask.

## Operation
- Pending update each cycle:
  - pending_next = (pending & ~clr) | req.
  - clr is the one-hot bit of `gnt_id` when `gnt_valid & gnt_ack`, else 0.
  - A `req` on the bit being cleared wins, so the requester re-pends.
- Mask: on `mask_we`, mask <= `mask_wdata` at the edge. eligible = pending & mask (registered values).
- Pointer: `last` (5 bits) holds the index of the last accepted grant.
- Selection:
  - above[i] = (i > last).
  - Round-robin: winner = lowbit(eligible & above) if that is nonzero, else lowbit(eligible).
  - Fixed: winner = lowbit(eligible).
  - lowbit returns 1..32, or 0 for none.
- FSM states IDLE and OFFER:
  - IDLE: if eligible != 0, load `gnt_id` <= winner, set `gnt_valid` <= 1, go to OFFER. Otherwise stay.
  - OFFER: hold `gnt_id` stable; no retraction, even if the mask or `rr_mode` changes. On `gnt_ack`: clear the pending bit, set `last` <= gnt_id-1, drive `gnt_valid` <= 0 and `gnt_id` <= 0, go to IDLE.
- `gnt_ack` in IDLE is ignored.
- Mask or `rr_mode` changes affect only the next IDLE selection.
- A masked pending bit stays pending and is offered once re-enabled.

## Timing
- Reset (`reset_n` = 0 at an edge, any state): pending = 0, mask = 32'hFFFFFFFF, `last` = 31, state = IDLE, `gnt_valid` = 0, `gnt_id` = 0. An in-flight offer is dropped.
- Latency: `req` high in cycle t gives pending set after edge t, and `gnt_valid` = 1 after edge t+1, i.e. 2 cycles.
- Acceptance happens on the edge where `gnt_valid & gnt_ack` = 1.
- Back-to-back grants have one IDLE bubble cycle between them. Maximum throughput is 1 grant per 2 cycles.
- With `last` = 31, round-robin reduces to fixed priority, because `above` is empty.
- Wrap-around: when no eligible bit lies above `last`, the search restarts from bit 0.
- Requests all zero, or all pending bits masked: stay in IDLE, `gnt_id` = 0.

## Structure
- Shared package holds:
  - `N_REQ` = 32, id width 6, `ST_IDLE`/`ST_OFFER` encodings.
  - `ID_NONE` = 0, `MASK_RST` = 32'hFFFFFFFF, `LAST_RST` = 31.
- One natural sub-module: `lowbit` (32-bit lowest-set-bit encoder, 1-based, 0 = none), instantiated twice: one copy on `eligible & above`, one on `eligible`.
- Everything else (pending, mask, `last`, FSM, above-mask generator) lives in `lowbit_sched`.

## Test plan
- Reset then a single pulse: req = 32'h00000010 for one cycle → `gnt_valid` = 1 two cycles later, `gnt_id` = 5. Ack → pending = 0, `gnt_id` = 0.
- Fixed priority: pending = 32'h80000011, `rr_mode` = 0, ack every offer → ids 1, 5, 32, with one bubble between each.
- Round-robin wrap: `rr_mode` = 1, req line 32'h00000011 held high → ids 1, 5, 1, 5… Requesters re-pend on the clear cycle.
- Mask: pending = 32'h00000006, mask = 32'hFFFFFFFD → id 3 only, pending stays 32'h00000002. Writing mask = all-ones → id 2.
- Hold under change: offer id 3 outstanding, mask bit 2 cleared and `rr_mode` toggled → `gnt_id` stays 3 until ack.
- Reset mid-offer: `reset_n` = 0 while `gnt_valid` = 1, id 7 → next cycle `gnt_valid` = 0, `gnt_id` = 0, pending = 0, mask = all-ones.
